// File: rtl/decoder_seq_pkg.sv
// Shared types and helpers for the decoder select sequencer.
package decoder_seq_pkg;

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  localparam int unsigned CODE_W    = 2;
  localparam int unsigned ERR_CNT_W = 3;

  function automatic logic [3:0] onehot4(input logic [CODE_W-1:0] code);
    onehot4 = 4'b0001 << code;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// 8-bit dwell counter; terminal flags the last cycle of a code's dwell.
module dwell_counter #(
  parameter int unsigned DWELL = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  localparam logic [7:0] Last = 8'(DWELL - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == Last);

endmodule

// File: rtl/decoder_select_seq.sv
// Walks the 2-to-4 decoder selects through 00..11 with a programmable dwell.
// Optional output checker enabled by defining DEC_CHECK_EN.
module decoder_select_seq
  import decoder_seq_pkg::*;
#(
  parameter int unsigned DWELL = 10,
  parameter bit          LOOP  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  output logic                 a0,
  output logic                 a1,
  output logic                 valid,
  output logic                 busy,
  output logic                 done
`ifdef DEC_CHECK_EN
  ,
  input  logic                 y0,
  input  logic                 y1,
  input  logic                 y2,
  input  logic                 y3,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                cnt_clr, cnt_en, terminal;

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .terminal (terminal)
  );

  // Counter is held clear outside DRIVE so every sequence starts at count 0.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b1;
    unique case (state_q)
      StIdle: begin
        code_d = '0;
        if (start && !stop) begin
          state_d = StDrive;
        end
      end
      StDrive: begin
        cnt_en  = 1'b1;
        cnt_clr = 1'b0;
        if (stop) begin
          state_d = StIdle;
          code_d  = '0;
          cnt_clr = 1'b1;
        end else if (terminal) begin
          cnt_clr = 1'b1;
          if (code_q != '1) begin
            code_d = code_q + 1'b1;
          end else if (LOOP) begin
            code_d = '0;
          end else begin
            state_d = StDone;
            code_d  = '0;
          end
        end
      end
      StDone: begin
        code_d  = '0;
        state_d = StIdle;
      end
      default: begin
        code_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // code_q is forced to 00 outside DRIVE, so the selects come straight off it.
  assign a0    = code_q[0];
  assign a1    = code_q[1];
  assign valid = (state_q == StDrive);
  assign busy  = (state_q == StDrive);
  assign done  = (state_q == StDone);

`ifdef DEC_CHECK_EN
  logic                 err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 seq_start, sample, mismatch;

  assign seq_start = (state_q == StIdle) && start && !stop;
  assign sample    = (state_q == StDrive) && terminal;
  assign mismatch  = ({y3, y2, y1, y0} != onehot4(code_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (seq_start) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (sample && mismatch) begin
      err_q <= 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_select_seq.sv
// Directed bench for decoder_select_seq: three instances cover DWELL=10, DWELL=1 and LOOP mode.
module tb_decoder_select_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic s10, p10, s1, p1, sl, pl;
  logic a0_10, a1_10, v10, b10, d10;
  logic a0_1, a1_1, v1, b1, d1;
  logic a0_l, a1_l, vl, bl, dl;
  logic [4:0] obs10, obs1, obsl;

  assign obs10 = {d10, b10, v10, a1_10, a0_10};
  assign obs1  = {d1, b1, v1, a1_1, a0_1};
  assign obsl  = {dl, bl, vl, a1_l, a0_l};

  int n_tests = 0;
  int n_fail  = 0;
  int dones;

`ifdef DEC_CHECK_EN
  logic       y2_bad;
  logic [3:0] y10, y1v, yl;
  logic       e10, e1, el;
  logic [2:0] c10, c1, cl;
  assign y10 = 4'b0001 << {a1_10, a0_10};
  assign y1v = 4'b0001 << {a1_1, a0_1};
  assign yl  = (4'b0001 << {a1_l, a0_l}) & (y2_bad ? 4'b1011 : 4'b1111);
`endif

  decoder_select_seq #(.DWELL(10), .LOOP(1'b0)) u_d10 (
    .clk(clk), .rst_n(rst_n), .start(s10), .stop(p10),
    .a0(a0_10), .a1(a1_10), .valid(v10), .busy(b10), .done(d10)
`ifdef DEC_CHECK_EN
    , .y0(y10[0]), .y1(y10[1]), .y2(y10[2]), .y3(y10[3]), .err(e10), .err_cnt(c10)
`endif
  );

  decoder_select_seq #(.DWELL(1), .LOOP(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .stop(p1),
    .a0(a0_1), .a1(a1_1), .valid(v1), .busy(b1), .done(d1)
`ifdef DEC_CHECK_EN
    , .y0(y1v[0]), .y1(y1v[1]), .y2(y1v[2]), .y3(y1v[3]), .err(e1), .err_cnt(c1)
`endif
  );

  decoder_select_seq #(.DWELL(3), .LOOP(1'b1)) u_loop (
    .clk(clk), .rst_n(rst_n), .start(sl), .stop(pl),
    .a0(a0_l), .a1(a1_l), .valid(vl), .busy(bl), .done(dl)
`ifdef DEC_CHECK_EN
    , .y0(yl[0]), .y1(yl[1]), .y2(yl[2]), .y3(yl[3]), .err(el), .err_cnt(cl)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {done, busy, valid, a1, a0} while driving a code
  function automatic logic [4:0] run_obs(input int code);
    logic [1:0] c;
    c = code[1:0];
    return {3'b011, c};
  endfunction

  initial begin
    rst_n = 1'b0;
    {s10, p10, s1, p1, sl, pl} = '0;
`ifdef DEC_CHECK_EN
    y2_bad = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_d10", obs10, 5'b0);
    check("reset_d1", obs1, 5'b0);
    check("reset_loop", obsl, 5'b0);
    rst_n = 1'b1;

    // Full DWELL=10 sequence
    @(negedge clk) s10 = 1'b1;
    @(negedge clk) s10 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      check("d10_seq", obs10, run_obs(k / 10));
      @(negedge clk);
    end
    check("d10_done", obs10, 5'b10000);
    s10 = 1'b1;
    @(negedge clk) s10 = 1'b0;
    check("d10_idle_after_done", obs10, 5'b0);
    @(negedge clk);
    check("d10_start_in_done_ignored", obs10, 5'b0);

    // Abort at cycle 15 of a run, then restart
    @(negedge clk) s10 = 1'b1;
    @(negedge clk) s10 = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_pre", obs10, run_obs(1));
    p10 = 1'b1;
    @(negedge clk) p10 = 1'b0;
    check("abort_idle", obs10, 5'b0);
    dones = 0;
    for (int k = 0; k < 45; k++) begin
      if (d10) dones++;
      @(negedge clk);
    end
    check("abort_no_done", dones, 0);
    s10 = 1'b1;
    @(negedge clk) s10 = 1'b0;
    check("restart_code0", obs10, run_obs(0));
    repeat (10) @(negedge clk);
    check("restart_code1", obs10, run_obs(1));
    p10 = 1'b1;
    @(negedge clk) p10 = 1'b0;

    // DWELL=1: stop priority in IDLE, then one-cycle codes
    s1 = 1'b1;
    p1 = 1'b1;
    @(negedge clk) {s1, p1} = 2'b00;
    check("idle_stop_prio", obs1, 5'b0);
    s1 = 1'b1;
    @(negedge clk) s1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("d1_seq", obs1, run_obs(k));
      @(negedge clk);
    end
    check("d1_done", obs1, 5'b10000);
    @(negedge clk);
    check("d1_idle", obs1, 5'b0);

    // LOOP=1, DWELL=3: two passes wrap with no done, stop ends it
    sl = 1'b1;
    @(negedge clk) sl = 1'b0;
    for (int k = 0; k < 24; k++) begin
      check("loop_seq", obsl, run_obs((k / 3) % 4));
      @(negedge clk);
    end
    check("loop_wrap", obsl, run_obs(0));
    pl = 1'b1;
    @(negedge clk) pl = 1'b0;
    check("loop_stop", obsl, 5'b0);

    // Reset in the middle of DRIVE
    sl = 1'b1;
    @(negedge clk) sl = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pre", obsl, run_obs(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid", obsl, 5'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_after", obsl, 5'b0);

`ifdef DEC_CHECK_EN
    check("chk_clean_err", el, 1'b0);
    check("chk_clean_cnt", cl, 3'd0);
    y2_bad = 1'b1;
    sl = 1'b1;
    @(negedge clk) sl = 1'b0;
    repeat (12) @(negedge clk);
    check("chk_err_1pass", el, 1'b1);
    check("chk_cnt_1pass", cl, 3'd1);
    repeat (24) @(negedge clk);
    check("chk_cnt_3pass", cl, 3'd3);
    repeat (60) @(negedge clk);
    check("chk_cnt_sat", cl, 3'd7);
    pl = 1'b1;
    @(negedge clk) pl = 1'b0;
    check("chk_hold_idle", cl, 3'd7);
    y2_bad = 1'b0;
    sl = 1'b1;
    @(negedge clk) sl = 1'b0;
    check("chk_clear_err", el, 1'b0);
    check("chk_clear_cnt", cl, 3'd0);
    pl = 1'b1;
    @(negedge clk) pl = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
